// File: rtl/ball_engine.sv
// ball_engine: breakout ball mover with serve/miss/over sequencing, lives,
// saturating score and per-block hit bookkeeping for NBLK blocks.
// Build option: define BALL_SPEED_RAMP_EN to raise the x/y step by one every
// RAMP_HITS paddle hits (capped at MAX_INC); otherwise steps are INC_X/INC_Y.
//
// state | meaning
// IDLE  | game mode off or not started, ball parked at serve point
// SERVE | ball held at serve point for SERVE_FRAMES gated strobes
// PLAY  | ball moving, walls/paddle/blocks/score active
// MISS  | single cycle, one life taken
// OVER  | game lost or won, waits for start
module ball_engine #(
  parameter int CW              = 12,
  parameter int NBLK            = 17,
  parameter int SW              = 9,
  parameter int LW              = 3,
  parameter int LIVES           = 3,
  parameter int H_SIZE          = 8,
  parameter int IX              = 320,
  parameter int IY              = 240,
  parameter int IY_DIR          = 0,
  parameter int INC_X           = 3,
  parameter int INC_Y           = 3,
  parameter int MAX_INC         = 7,
  parameter int RAMP_HITS       = 4,
  parameter int SCORE_PER_BLOCK = 5,
  parameter int SERVE_FRAMES    = 60,
  parameter int PY              = 460,
  parameter int PH              = 10,
  parameter int D_WIDTH         = 640,
  parameter int D_HEIGHT        = 480
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_ani_stb,
  input  logic              i_animate,
  input  logic              i_mode,
  input  logic              i_start,
  input  logic [CW-1:0]     i_pad_x1,
  input  logic [CW-1:0]     i_pad_x2,
  input  logic [1:0]        i_com,
  input  logic [2*NBLK-1:0] i_hit_block,
  output logic [CW-1:0]     o_x,
  output logic [CW-1:0]     o_y,
  output logic [CW-1:0]     o_x1,
  output logic [CW-1:0]     o_x2,
  output logic [CW-1:0]     o_y1,
  output logic [CW-1:0]     o_y2,
  output logic [SW-1:0]     o_score,
  output logic [LW-1:0]     o_lives,
  output logic [2:0]        o_state,
  output logic              o_endgame,
  output logic [NBLK-1:0]   o_col_detected
);

  typedef enum logic [2:0] {IDLE = 3'd0, SERVE = 3'd1, PLAY = 3'd2, MISS = 3'd3, OVER = 3'd4} state_t;

  localparam int FCW  = $clog2(SERVE_FRAMES + 1);
  localparam int CNTW = $clog2(NBLK + 1);
  localparam int ADDW = SW + CNTW + 8;
  localparam logic [CW-1:0]   X_SERVE   = CW'(IX);
  localparam logic [CW-1:0]   Y_SERVE   = CW'(IY);
  localparam logic [CW-1:0]   X_MIN     = CW'(H_SIZE);
  localparam logic [CW-1:0]   Y_MIN     = CW'(H_SIZE);
  localparam logic [CW-1:0]   X_MAX     = CW'(D_WIDTH - H_SIZE - 1);
  localparam logic [CW-1:0]   Y_MAX     = CW'(D_HEIGHT - H_SIZE - 1);
  localparam logic [CW-1:0]   PAD_TOP   = CW'(PY - PH);
  localparam logic [ADDW-1:0] SCORE_MAX = ADDW'((2 ** SW) - 1);
  localparam logic [FCW-1:0]  FRAME_TC  = FCW'(SERVE_FRAMES - 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    x_q, x_d, y_q, y_d;
  logic             xdir_q, xdir_d, ydir_q, ydir_d;
  logic [SW-1:0]    score_q, score_d;
  logic [LW-1:0]    lives_q, lives_d;
  logic [NBLK-1:0]  col_q, col_d;
  logic             endgame_q, endgame_d;
  logic [FCW-1:0]   frame_q, frame_d;
  logic [15:0]      lfsr_q;

  logic             stb, pad_hit, pad_bounce, serve_entry;
  logic [CW-1:0]    step_x, step_y, x_fwd, x_back, y_fwd, y_back;
  logic [CW:0]      x_sum, y_sum;
  logic [NBLK-1:0]  new_hit;
  logic             v_any, h_any;
  logic [CNTW-1:0]  hit_cnt;
  logic [ADDW-1:0]  score_sum;
  logic [SW-1:0]    score_sat;

  assign stb  = i_ani_stb & i_animate;
  assign o_x  = x_q;
  assign o_y  = y_q;
  assign o_x1 = x_q - CW'(H_SIZE);
  assign o_x2 = x_q + CW'(H_SIZE);
  assign o_y1 = y_q - CW'(H_SIZE);
  assign o_y2 = y_q + CW'(H_SIZE);
  assign o_score        = score_q;
  assign o_lives        = lives_q;
  assign o_state        = state_q;
  assign o_endgame      = endgame_q;
  assign o_col_detected = col_q;

  assign pad_hit    = ydir_q && (o_y2 >= PAD_TOP) && (o_x1 <= i_pad_x2) && (o_x2 >= i_pad_x1);
  assign pad_bounce = (state_q == PLAY) && stb && pad_hit;
  assign serve_entry = (state_d == SERVE) && (state_q != SERVE);

  // Clamped candidate positions; the extra bit keeps the add from wrapping.
  assign x_sum  = {1'b0, x_q} + {1'b0, step_x};
  assign y_sum  = {1'b0, y_q} + {1'b0, step_y};
  assign x_fwd  = (x_sum >= {1'b0, X_MAX}) ? X_MAX : x_sum[CW-1:0];
  assign y_fwd  = (y_sum >= {1'b0, Y_MAX}) ? Y_MAX : y_sum[CW-1:0];
  assign x_back = ({1'b0, x_q} <= {1'b0, X_MIN} + {1'b0, step_x}) ? X_MIN : x_q - step_x;
  assign y_back = ({1'b0, y_q} <= {1'b0, Y_MIN} + {1'b0, step_y}) ? Y_MIN : y_q - step_y;

  // Merge block codes from blocks not yet destroyed into one toggle per axis.
  always_comb begin
    new_hit = '0;
    v_any   = 1'b0;
    h_any   = 1'b0;
    hit_cnt = '0;
    for (int k = 0; k < NBLK; k++) begin
      if ((i_hit_block[2*k +: 2] != 2'b00) && !col_q[k]) begin
        new_hit[k] = 1'b1;
        v_any      = v_any | i_hit_block[2*k];
        h_any      = h_any | i_hit_block[2*k+1];
        hit_cnt    = hit_cnt + CNTW'(1);
      end
    end
  end

  assign score_sum = ADDW'(score_q) + ADDW'(hit_cnt) * ADDW'(SCORE_PER_BLOCK);
  assign score_sat = (score_sum > SCORE_MAX) ? {SW{1'b1}} : score_sum[SW-1:0];

`ifdef BALL_SPEED_RAMP_EN
  localparam int HCW = $clog2(RAMP_HITS + 1);
  logic [CW-1:0]  stepx_q, stepx_d, stepy_q, stepy_d;
  logic [HCW-1:0] hits_q, hits_d;

  assign step_x = stepx_q;
  assign step_y = stepy_q;

  // Paddle-hit down-counter; each terminal count bumps both steps up to the ceiling.
  always_comb begin
    stepx_d = stepx_q;
    stepy_d = stepy_q;
    hits_d  = hits_q;
    if (serve_entry || (state_d == IDLE)) begin
      stepx_d = CW'(INC_X);
      stepy_d = CW'(INC_Y);
      hits_d  = HCW'(RAMP_HITS - 1);
    end else if (pad_bounce) begin
      if (hits_q == '0) begin
        hits_d = HCW'(RAMP_HITS - 1);
        if (stepx_q < CW'(MAX_INC)) stepx_d = stepx_q + CW'(1);
        if (stepy_q < CW'(MAX_INC)) stepy_d = stepy_q + CW'(1);
      end else begin
        hits_d = hits_q - HCW'(1);
      end
    end
  end

  // Ramp registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      stepx_q <= CW'(INC_X);
      stepy_q <= CW'(INC_Y);
      hits_q  <= HCW'(RAMP_HITS - 1);
    end else begin
      stepx_q <= stepx_d;
      stepy_q <= stepy_d;
      hits_q  <= hits_d;
    end
  end
`else
  // Fixed steps, never above the ceiling.
  assign step_x = CW'((INC_X > MAX_INC) ? MAX_INC : INC_X);
  assign step_y = CW'((INC_Y > MAX_INC) ? MAX_INC : INC_Y);
  if (RAMP_HITS < 1) begin : g_ramp_hits_unset
  end
`endif

  // Next-state, motion, collision and bookkeeping; mode low overrides everything.
  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    xdir_d    = xdir_q;
    ydir_d    = ydir_q;
    score_d   = score_q;
    lives_d   = lives_q;
    col_d     = col_q;
    endgame_d = endgame_q;
    frame_d   = frame_q;
    case (state_q)
      IDLE: begin
        x_d    = X_SERVE;
        y_d    = Y_SERVE;
        xdir_d = 1'b0;
        ydir_d = (IY_DIR != 0);
        if (i_start) begin
          state_d = SERVE;
          score_d = '0;
          lives_d = LW'(LIVES);
          col_d   = '0;
          xdir_d  = lfsr_q[0];
          frame_d = FRAME_TC;
        end
      end
      SERVE: begin
        if (stb) begin
          if (frame_q == '0) state_d = PLAY;
          else               frame_d = frame_q - FCW'(1);
        end
      end
      PLAY: begin
        if (stb) begin
          x_d     = xdir_q ? x_fwd : x_back;
          y_d     = ydir_q ? y_fwd : y_back;
          col_d   = col_q | new_hit;
          score_d = score_sat;
          if (h_any) xdir_d = ~xdir_q;
          if (v_any) ydir_d = ~ydir_q;
          if (x_q <= X_MIN + CW'(1)) xdir_d = 1'b1;
          if (x_q >= X_MAX)          xdir_d = 1'b0;
          if (y_q <= Y_MIN + CW'(1)) ydir_d = 1'b1;
          if (pad_hit) begin
            ydir_d = 1'b0;
            if (i_com == 2'b10)      xdir_d = 1'b0;
            else if (i_com == 2'b01) xdir_d = 1'b1;
          end
          if (&(col_q | new_hit)) begin
            state_d   = OVER;
            endgame_d = 1'b1;
          end else if ((y_q >= Y_MAX) && !pad_hit) begin
            state_d = MISS;
          end
        end
      end
      MISS: begin
        lives_d = lives_q - LW'(1);
        x_d     = X_SERVE;
        y_d     = Y_SERVE;
        ydir_d  = (IY_DIR != 0);
        if (lives_q <= LW'(1)) begin
          state_d   = OVER;
          endgame_d = 1'b1;
        end else begin
          state_d = SERVE;
          xdir_d  = lfsr_q[0];
          frame_d = FRAME_TC;
        end
      end
      OVER: begin
        x_d       = X_SERVE;
        y_d       = Y_SERVE;
        ydir_d    = (IY_DIR != 0);
        endgame_d = 1'b1;
        if (i_start) begin
          state_d   = SERVE;
          lives_d   = LW'(LIVES);
          score_d   = '0;
          col_d     = '0;
          endgame_d = 1'b0;
          xdir_d    = lfsr_q[0];
          frame_d   = FRAME_TC;
        end
      end
      default: state_d = IDLE;
    endcase
    if (!i_mode) begin
      state_d   = IDLE;
      x_d       = X_SERVE;
      y_d       = Y_SERVE;
      xdir_d    = 1'b0;
      ydir_d    = (IY_DIR != 0);
      score_d   = '0;
      lives_d   = LW'(LIVES);
      col_d     = '0;
      endgame_d = 1'b0;
    end
  end

  // State, datapath and free-running serve-direction LFSR registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= IDLE;
      x_q       <= X_SERVE;
      y_q       <= Y_SERVE;
      xdir_q    <= 1'b0;
      ydir_q    <= (IY_DIR != 0);
      score_q   <= '0;
      lives_q   <= LW'(LIVES);
      col_q     <= '0;
      endgame_q <= 1'b0;
      frame_q   <= FRAME_TC;
      lfsr_q    <= 16'hACE1;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      xdir_q    <= xdir_d;
      ydir_q    <= ydir_d;
      score_q   <= score_d;
      lives_q   <= lives_d;
      col_q     <= col_d;
      endgame_q <= endgame_d;
      frame_q   <= frame_d;
      lfsr_q    <= {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    end
  end

endmodule

// File: tb/tb_ball_engine.sv
// Directed bench for ball_engine: a default instance plus a second instance
// with a large per-block score sharing the same stimulus to reach saturation.
module tb_ball_engine;
  localparam int CW = 12, NBLK = 17, SW = 9, LW = 3;

  logic              clk = 1'b0;
  logic              rst, ani_stb, animate, mode, start;
  logic [CW-1:0]     pad_x1, pad_x2;
  logic [1:0]        com;
  logic [2*NBLK-1:0] hit;

  logic [CW-1:0]   x, y, x1, x2, y1, y2;
  logic [SW-1:0]   score;
  logic [LW-1:0]   lives;
  logic [2:0]      state;
  logic            endgame;
  logic [NBLK-1:0] col;

  logic [CW-1:0]   s_x, s_y, s_x1, s_x2, s_y1, s_y2;
  logic [SW-1:0]   s_score;
  logic [LW-1:0]   s_lives;
  logic [2:0]      s_state;
  logic            s_endgame;
  logic [NBLK-1:0] s_col;

  int n_cmp = 0;
  int n_bad = 0;
  logic [15:0] lfsr_m;
  int sx, sx2;
  logic [1:0] steer;

  ball_engine dut (
    .i_clk(clk), .i_rst(rst), .i_ani_stb(ani_stb), .i_animate(animate), .i_mode(mode),
    .i_start(start), .i_pad_x1(pad_x1), .i_pad_x2(pad_x2), .i_com(com), .i_hit_block(hit),
    .o_x(x), .o_y(y), .o_x1(x1), .o_x2(x2), .o_y1(y1), .o_y2(y2), .o_score(score),
    .o_lives(lives), .o_state(state), .o_endgame(endgame), .o_col_detected(col)
  );

  ball_engine #(.SCORE_PER_BLOCK(127)) dut_sat (
    .i_clk(clk), .i_rst(rst), .i_ani_stb(ani_stb), .i_animate(animate), .i_mode(mode),
    .i_start(start), .i_pad_x1(pad_x1), .i_pad_x2(pad_x2), .i_com(com), .i_hit_block(hit),
    .o_x(s_x), .o_y(s_y), .o_x1(s_x1), .o_x2(s_x2), .o_y1(s_y1), .o_y2(s_y2), .o_score(s_score),
    .o_lives(s_lives), .o_state(s_state), .o_endgame(s_endgame), .o_col_detected(s_col)
  );

  always #5 clk = ~clk;

  // Reference serve-direction LFSR, seeded and stepped like the design's.
  always @(posedge clk or posedge rst) begin
    if (rst) lfsr_m <= 16'hACE1;
    else     lfsr_m <= {lfsr_m[0] ^ lfsr_m[2] ^ lfsr_m[3] ^ lfsr_m[5], lfsr_m[15:1]};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [2*NBLK-1:0] blk(input int k, input logic [1:0] code);
    logic [2*NBLK-1:0] v;
    v = '0;
    v[2*k +: 2] = code;
    return v;
  endfunction

  // One idle cycle, then one strobe cycle; returns just after the strobe edge.
  task automatic strobe(input logic gate, input logic [2*NBLK-1:0] h, input logic [1:0] c);
    @(negedge clk);
    ani_stb = 1'b1; animate = gate; hit = h; com = c;
    @(negedge clk);
    ani_stb = 1'b0; animate = 1'b1; hit = '0; com = 2'b00;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) strobe(1'b1, '0, 2'b00);
  endtask

  // Serve, turn the ball down with one block hit, let it fall past an absent paddle.
  task automatic lose_life(input int k, input int exp_a, input int exp_b);
    run(60);
    chk("serve_to_play", state, 2);
    strobe(1'b1, blk(k, 2'b01), 2'b00);
    chk("flip_y", y, 237);
    chk("flip_score", score, exp_a);
    chk("flip_score_sat", s_score, exp_b);
    run(78);
    chk("fall_bottom_y", y, 471);
    strobe(1'b1, '0, 2'b00);
    chk("miss_state", state, 3);
  endtask

  initial begin
    rst = 1'b1; ani_stb = 1'b0; animate = 1'b1; mode = 1'b0; start = 1'b0;
    pad_x1 = 12'd0; pad_x2 = 12'd639; com = 2'b00; hit = '0;
    repeat (2) @(negedge clk);
    chk("rst_state", state, 0);
    chk("rst_x", x, 320);
    chk("rst_y", y, 240);
    chk("rst_x1", x1, 312);
    chk("rst_x2", x2, 328);
    chk("rst_y1", y1, 232);
    chk("rst_y2", y2, 248);
    chk("rst_score", score, 0);
    chk("rst_lives", lives, 3);
    chk("rst_endgame", endgame, 0);
    chk("rst_col", col, 0);
    rst = 1'b0;
    mode = 1'b1;
    @(negedge clk);
    chk("idle_no_start", state, 0);

    // Start: serve direction is the LFSR bit at the transition edge.
    start = 1'b1;
    sx = lfsr_m[0] ? 3 : -3;
    @(negedge clk);
    start = 1'b0;
    chk("start_serve", state, 1);
    strobe(1'b0, '0, 2'b00);
    chk("gated_strobe_ignored", state, 1);
    run(59);
    chk("serve_59_state", state, 1);
    chk("serve_x", x, 320);
    chk("serve_y", y, 240);
    run(1);
    chk("serve_60_play", state, 2);
    chk("play_entry_x", x, 320);

    // Two vertical block hits on one strobe toggle y once: ball turns downward.
    strobe(1'b1, blk(2, 2'b01) | blk(5, 2'b01), 2'b00);
    chk("p1_x_lfsr_dir", x, 320 + sx);
    chk("p1_y", y, 237);
    chk("p1_score", score, 10);
    chk("p1_col", col, 32'h24);
    chk("p1_score_sat", s_score, 254);
    strobe(1'b1, blk(2, 2'b01), 2'b00);
    chk("p2_repeat_score", score, 10);
    chk("p2_y", y, 240);
    run(1);
    chk("p3_no_retoggle_y", y, 243);
    run(67);
    chk("p70_y", y, 444);
    chk("p70_x", x, 320 + 70 * sx);

    // Paddle hit with steering against the current horizontal direction.
    steer = (sx > 0) ? 2'b10 : 2'b01;
    strobe(1'b1, '0, steer);
    chk("pad_y", y, 447);
    chk("pad_x", x, 320 + 71 * sx);
    chk("pad_score", score, 10);
    run(1);
    chk("bounce_y", y, 444);
    chk("steer_x", x, 320 + 70 * sx);

    // Paddle moved off-screen; ball turned down again and lost.
    pad_x1 = 12'd700; pad_x2 = 12'd700;
    strobe(1'b1, blk(3, 2'b01), 2'b00);
    chk("l1_flip_y", y, 441);
    chk("l1_score", score, 15);
    chk("l1_score_sat", s_score, 381);
    run(10);
    chk("l1_bottom_y", y, 471);
    strobe(1'b1, '0, 2'b00);
    chk("l1_clamp_y", y, 471);
    chk("l1_miss_state", state, 3);
    chk("l1_miss_lives", lives, 3);
    @(negedge clk);
    chk("l1_reserve", state, 1);
    chk("l1_lives", lives, 2);
    chk("l1_x", x, 320);
    chk("l1_y", y, 240);

    lose_life(4, 20, 508);
    @(negedge clk);
    chk("l2_lives", lives, 1);
    chk("l2_reserve", state, 1);

    lose_life(6, 25, 511);
    chk("l3_miss_lives", lives, 1);
    @(negedge clk);
    chk("over_state", state, 4);
    chk("over_lives", lives, 0);
    chk("over_endgame", endgame, 1);
    chk("over_x", x, 320);
    chk("over_y", y, 240);
    chk("over_col", col, 32'h7C);
    @(negedge clk);
    chk("over_hold", state, 4);

    // Restart from OVER.
    start = 1'b1;
    sx2 = lfsr_m[0] ? 3 : -3;
    @(negedge clk);
    start = 1'b0;
    chk("restart_state", state, 1);
    chk("restart_lives", lives, 3);
    chk("restart_score", score, 0);
    chk("restart_score_sat", s_score, 0);
    chk("restart_col", col, 0);
    chk("restart_endgame", endgame, 0);
    run(60);
    chk("restart_play", state, 2);

    // Horizontal block hit reverses x; ball climbs to the top wall.
    strobe(1'b1, blk(7, 2'b10), 2'b00);
    chk("h_p1_x", x, 320 + sx2);
    chk("h_p1_score", score, 5);
    run(1);
    chk("h_p2_x_reversed", x, 320);
    chk("h_p2_y", y, 234);
    run(75);
    chk("top_near_y", y, 9);
    run(1);
    chk("top_clamp_y", y, 8);
    run(1);
    chk("top_bounce_y", y, 11);
    chk("top_x", x, 320 - 77 * sx2);
    strobe(1'b0, '0, 2'b00);
    chk("hold_y", y, 11);
    chk("hold_x", x, 320 - 77 * sx2);

    // Mode dropped mid-PLAY.
    mode = 1'b0;
    @(negedge clk);
    chk("mode_off_state", state, 0);
    chk("mode_off_score", score, 0);
    chk("mode_off_col", col, 0);
    chk("mode_off_lives", lives, 3);
    chk("mode_off_x", x, 320);
    chk("mode_off_y", y, 240);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
